// File: rtl/mac_carry_pipe_pkg.sv
// rtl/mac_carry_pipe_pkg.sv - shared widths, sum-width helper and S1 payload type for mac_carry_pipe
package mac_carry_pkg;

  localparam int A_W_DEF   = 7;
  localparam int B_W_DEF   = 7;
  localparam int C_W_DEF   = 6;
  localparam int OUT_W_DEF = 14;

  // The S2 adder keeps one bit above the result so the carry is never lost.
  function automatic int sum_width(input int out_w);
    return out_w + 1;
  endfunction

  localparam int SUM_W_DEF = sum_width(OUT_W_DEF);

  // S1 payload in the default configuration; parametrised builds carry the
  // same fields with their own widths inside the stage.
  typedef struct packed {
    logic [A_W_DEF+B_W_DEF-1:0] prod;
    logic [C_W_DEF-1:0]         c;
    logic                       acc_en;
    logic                       valid;
  } s1_payload_t;

endpackage

// File: rtl/mac_carry_pipe_if.sv
// rtl/mac_carry_pipe_if.sv - input/output handshake bundle for mac_carry_pipe
interface mac_carry_pipe_if #(
  parameter int A_W   = 7,
  parameter int B_W   = 7,
  parameter int C_W   = 6,
  parameter int OUT_W = 14
) ();

  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [C_W-1:0]   c;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
  logic             cout;
  logic             ovf;

  // Producer/consumer side that drives operands and accepts results.
  modport master (
    output in_valid, a, b, c, acc_en, out_ready,
    input  in_ready, out_valid, out, cout, ovf
  );

  // The MAC pipeline itself.
  modport slave (
    input  in_valid, a, b, c, acc_en, out_ready,
    output in_ready, out_valid, out, cout, ovf
  );

endinterface

// File: rtl/mac_carry_pipe_mul_stage.sv
// rtl/mac_carry_pipe_mul_stage.sv - S1: registered product plus addend/acc_en with its own valid/advance
module mac_mul_stage
  import mac_carry_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  input  logic [C_W-1:0]     c,
  input  logic               acc_en,
  input  logic               s2_adv,
  output logic               in_ready,
  output logic               s1_valid,
  output logic [A_W+B_W-1:0] prod,
  output logic [C_W-1:0]     c_q,
  output logic               acc_en_q
);

  localparam int P_W = A_W + B_W;

  // S1 may take a new beat when it is empty or its beat moves into S2.
  assign in_ready = !s1_valid || s2_adv;

  // Register the full-width product; payload only changes on a real accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      prod     <= '0;
      c_q      <= '0;
      acc_en_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        prod     <= P_W'(a) * P_W'(b);
        c_q      <= c;
        acc_en_q <= acc_en;
      end
    end
  end

endmodule

// File: rtl/mac_carry_pipe.sv
// rtl/mac_carry_pipe.sv - two-stage a*b+c(+acc) with carry and sticky overflow; optional MAC_CARRY_PIPE_SAT_EN saturation
module mac_carry_pipe
  import mac_carry_pkg::*;
#(
  parameter int A_W   = 7,
  parameter int B_W   = 7,
  parameter int C_W   = 6,
  parameter int OUT_W = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_carry_pipe_if.slave bus
);

  localparam int SUM_W = sum_width(OUT_W);

  if (OUT_W < A_W + B_W || OUT_W < C_W) begin : g_bad_width
    $error("mac_carry_pipe: OUT_W must be >= A_W+B_W and >= C_W");
  end

  logic               s2_adv;
  logic               s1_valid;
  logic [A_W+B_W-1:0] prod;
  logic [C_W-1:0]     c_q;
  logic               acc_en_q;

  logic               out_valid_q;
  logic [OUT_W-1:0]   out_q;
  logic               cout_q;
  logic               ovf_q;

  logic [SUM_W-1:0]   sum;
  logic [OUT_W-1:0]   out_next;
  logic               cout_next;
  logic               ovf_next;

  // S2 moves whenever its result is absent or being taken this cycle.
  assign s2_adv = !out_valid_q || bus.out_ready;

  mac_mul_stage #(
    .A_W (A_W),
    .B_W (B_W),
    .C_W (C_W)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (bus.in_valid),
    .a        (bus.a),
    .b        (bus.b),
    .c        (bus.c),
    .acc_en   (bus.acc_en),
    .s2_adv   (s2_adv),
    .in_ready (bus.in_ready),
    .s1_valid (s1_valid),
    .prod     (prod),
    .c_q      (c_q),
    .acc_en_q (acc_en_q)
  );

  // The accumulator is the output register, so the fold-back always sees the last emitted result.
  always_comb begin
    sum       = SUM_W'(prod) + SUM_W'(c_q) + (acc_en_q ? SUM_W'(out_q) : '0);
    cout_next = sum[OUT_W];
`ifdef MAC_CARRY_PIPE_SAT_EN
    out_next  = cout_next ? '1 : sum[OUT_W-1:0];
`else
    out_next  = sum[OUT_W-1:0];
`endif
    ovf_next  = acc_en_q ? (ovf_q | cout_next) : cout_next;
  end

  // S2 result register; holds everything while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_q  <= out_next;
        cout_q <= cout_next;
        ovf_q  <= ovf_next;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
